// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the data port and the shared memory port of mem_arbiter.
//   slave  : arbiter view (requests and memory response in, completions and memory request out)
//   master : environment view (requesters plus memory model)
// Fetch:  if_req, if_addr -> if_ready, if_rdata
// Data:   d_req, d_we, d_addr, d_wdata -> d_ready, d_rdata
// Memory: mem_valid, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
// Status: err (timeout, valid with a ready pulse), busy (arbiter not idle)
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        err;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata,
        output err, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata,
        input  err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and data) in front of a single memory port.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times in a row; a memory
// access that sees no mem_ack for MAX_WAIT busy cycles completes with err set and rdata 0.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_arbiter_if.slave carrying fetch, data, memory and status signals
module mem_arbiter #(
    parameter int unsigned MAX_WAIT     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD, StResp} state_e;

    // Timeout fires in the busy cycle whose count is MAX_WAIT-1, giving MAX_WAIT busy cycles.
    localparam logic [7:0] WaitLast  = 8'(MAX_WAIT - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sel_data_q, sel_data_d;  // 1: data side holds the grant
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        sel_data_d = sel_data_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                err_d  = 1'b0;
                wait_d = '0;
                if (bus.d_req && !(bus.if_req && starve_q == StarveMax)) begin
                    state_d    = StBusyD;
                    sel_data_d = 1'b1;
                    addr_d     = bus.d_addr;
                    we_d       = bus.d_we;
                    wdata_d    = bus.d_wdata;
                    // Count only grants that actually passed over a waiting fetch.
                    if (bus.if_req && starve_q != 4'hf) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (bus.if_req) begin
                    state_d    = StBusyIf;
                    sel_data_d = 1'b0;
                    addr_d     = bus.if_addr;
                    we_d       = 1'b0;
                    wdata_d    = '0;
                    starve_d   = '0;
                end
            end
            StBusyIf, StBusyD: begin
                if (bus.mem_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    if (state_q == StBusyD) begin
                        d_rdata_d = we_q ? '0 : bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (wait_q == WaitLast) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    if (state_q == StBusyD) begin
                        d_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            starve_q   <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            sel_data_q <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            sel_data_q <= sel_data_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // All outputs derive from registered state only, so requester inputs cannot disturb them.
    logic in_busy_if, in_busy_d, in_resp;
    assign in_busy_if = (state_q == StBusyIf);
    assign in_busy_d  = (state_q == StBusyD);
    assign in_resp    = (state_q == StResp);

    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_valid = in_busy_if | in_busy_d;
    assign bus.mem_we    = in_busy_d & we_q;
    assign bus.mem_addr  = (in_busy_if | in_busy_d) ? addr_q : '0;
    assign bus.mem_wdata = in_busy_d ? wdata_q : '0;
    assign bus.if_ready  = in_resp & ~sel_data_q;
    assign bus.d_ready   = in_resp & sel_data_q;
    assign bus.err       = in_resp & err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
